gs_stream_serializer: RTL
=========================

Name: gs_stream_serializer

Overview:
- Upstream neighbour of the driver controller; produces its 30-bit per-SCLK serial data word (framebuffer_dat).
- Reads one 270-bit word per (mux row, channel) from the framebuffer RAM. Each word holds 9-bit grayscale values for all 30 drivers.
- Shifts the values out MSB-first, one bit per driver per shift_en pulse.
- Prefetches the next RAM word so the controller never stalls mid-segment.

Parameters:
- NB_DRIVERS, 30, number of parallel driver SIN lines
- NB_CHANNELS, 48, GS channels per driver (R+G+B × 16)
- GS_BITS, 9, bits per channel (9-bit poker mode)
- NB_MUX, 8, multiplexed rows per slice
- ADDR_W, 10, RAM address width: {buffer_select, mux[2:0], channel[5:0]}

Ports:
- clk_lse  in  1  system clock; all logic on posedge
- nrst  in  1  synchronous active-low reset
- slice_start  in  1  single-cycle pulse: begin streaming a new slice
- buffer_select  in  1  framebuffer half to read, latched on slice_start
- ram_rd  out  1  RAM read strobe
- ram_addr  out  ADDR_W  RAM read address
- ram_dat  in  NB_DRIVERS*GS_BITS  read data; driver i at [i*GS_BITS +: GS_BITS]
- shift_en  in  1  controller consumed current bit (one per SCLK edge)
- drivers_dat  out  NB_DRIVERS  current bit per driver; feeds framebuffer_dat
- stream_ready  out  1  drivers_dat valid and shift_en accepted
- slice_done  out  1  single-cycle pulse after last bit of slice consumed
- underrun  out  1  sticky error flag

Behaviour:
- Reset (nrst=0 at posedge) puts the block in IDLE with these output values:
  - ram_rd=0, ram_addr=0, drivers_dat=0
  - stream_ready=0, slice_done=0, underrun=0
  - all counters and the holding-register valid flag cleared
- All outputs are registered except drivers_dat. drivers_dat = MSB of each driver's field in the shift register while in STREAM, else 0.
- RAM read latency is fixed at 1: ram_dat is valid at the posedge following the cycle ram_rd=1.
- Stream order:
  - mux 0..NB_MUX-1 ascending.
  - Within each mux, channel NB_CHANNELS-1 down to 0.
  - Within each channel, bit 8 down to bit 0.
  - Total 3456 shifts per slice.
- States: IDLE, PREFETCH, STREAM.
- IDLE:
  - On slice_start, latch buffer_select and set mux=0, ch=47.
  - Assert ram_rd with addr {sel,0,47} in the next cycle, then go to PREFETCH.
- PREFETCH:
  - Load ram_dat into the shift register and set bit_cnt=0.
  - Issue the read for the next address (ch=46) and go to STREAM.
  - stream_ready=1 from the cycle after the load, i.e. 3 cycles after slice_start is sampled.
- STREAM:
  - Returned prefetch data goes to the holding register and sets hold_valid.
  - Each shift_en shifts every driver field left by 1 and increments bit_cnt.
  - On the shift_en with bit_cnt=8:
    - Load the shift register from the holding register, clear hold_valid and set bit_cnt=0.
    - Issue the next read. Address order: decrement ch; ch wraps from 0 to 47 with mux+1.
  - If hold_valid=0 at that point, set underrun; the shift register loads zeros.
- End of slice:
  - The shift_en consuming bit 0 of mux 7, ch 0 triggers the end sequence.
  - stream_ready drops and slice_done pulses the next cycle; state returns to IDLE.
  - No read is issued past the last address.
- shift_en when stream_ready=0 (IDLE or PREFETCH) sets underrun and is otherwise ignored.
- slice_start in any state:
  - Aborts the current slice, clears underrun and hold_valid, and restarts from IDLE→PREFETCH sequencing.
  - slice_start wins over a simultaneous shift_en.
- At most one read is outstanding; ram_rd is never asserted on two consecutive cycles.
- Counter widths: bit_cnt 4b, ch 6b, mux 3b. No arithmetic overflow is possible inside the defined ranges.

Test Plan:
- Reset: hold nrst=0 with slice_start, shift_en toggling -> all outputs 0; underrun 0 after release.
- Basic load:
  - Stimulus: ram model returns driver i field = i for addr {0,0,47}; pulse slice_start.
  - Required: ram_rd with addr 0x02F; stream_ready 3 cycles later.
  - Required: 9 shift_en pulses yield drivers_dat bits 8..0 of each i (driver 5 -> 0,0,0,0,0,0,1,0,1).
- Full slice:
  - Stimulus: shift_en every cycle after ready.
  - Required: 384 reads in order 0x02F,0x02E..0x000,0x06F..0x1C0; slice_done once after shift 3456; underrun stays 0.
- Buffer select: slice_start with buffer_select=1 -> first address 0x22F; last address 0x3C0.
- Early shift: shift_en during PREFETCH -> underrun=1; stream continues correctly; next slice_start clears underrun.
- Mid-slice restart: slice_start after 100 shifts while shift_en is high -> restart at addr {sel,0,47}; bit_cnt=0; no slice_done from the aborted slice.

Source files
------------

// File: rtl/gs_stream_serializer.sv
// Framebuffer-to-driver serializer: fetches one 270-bit grayscale word per (mux, channel)
// and shifts each driver's 9-bit field out MSB-first, prefetching the next word into a holding register.
module gs_stream_serializer #(
  parameter int unsigned NB_DRIVERS  = 30,
  parameter int unsigned NB_CHANNELS = 48,
  parameter int unsigned GS_BITS     = 9,
  parameter int unsigned NB_MUX      = 8,
  parameter int unsigned ADDR_W      = 10
) (
  input  logic                          clk_lse,
  input  logic                          nrst,
  input  logic                          slice_start,
  input  logic                          buffer_select,
  output logic                          ram_rd,
  output logic [ADDR_W-1:0]             ram_addr,
  input  logic [NB_DRIVERS*GS_BITS-1:0] ram_dat,
  input  logic                          shift_en,
  output logic [NB_DRIVERS-1:0]         drivers_dat,
  output logic                          stream_ready,
  output logic                          slice_done,
  output logic                          underrun
);

  localparam int unsigned DW    = NB_DRIVERS * GS_BITS;
  localparam int unsigned CH_W  = $clog2(NB_CHANNELS);
  localparam int unsigned MUX_W = $clog2(NB_MUX);

  typedef enum logic [1:0] {IDLE, PREFETCH, STREAM} state_t;

  state_t            state_q, state_d;
  logic              start_q, start_d;
  logic              sel_q, sel_d;
  logic [MUX_W-1:0]  mux_q, mux_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic              last_q, last_d;
  logic [DW-1:0]     shreg_q, shreg_d;
  logic [DW-1:0]     hold_q, hold_d;
  logic              hold_valid_q, hold_valid_d;
  logic              pend_q, pend_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              underrun_q, underrun_d;

  logic [DW-1:0]         shifted;
  logic [NB_DRIVERS-1:0] msbs;
  logic [CH_W-1:0]       next_ch;
  logic [MUX_W-1:0]      next_mux;
  logic                  at_last_addr;

  always_comb begin
    shifted = '0;
    msbs    = '0;
    for (int unsigned i = 0; i < NB_DRIVERS; i++) begin
      shifted[i*GS_BITS +: GS_BITS] = {shreg_q[i*GS_BITS +: GS_BITS-1], 1'b0};
      msbs[i]                       = shreg_q[i*GS_BITS + GS_BITS - 1];
    end
  end

  assign drivers_dat = (state_q == STREAM) ? msbs : '0;

  // mux/ch always hold the most recently issued read address
  assign next_ch      = (ch_q == '0) ? CH_W'(NB_CHANNELS - 1) : ch_q - CH_W'(1);
  assign next_mux     = (ch_q == '0) ? mux_q + MUX_W'(1) : mux_q;
  assign at_last_addr = (mux_q == MUX_W'(NB_MUX - 1)) && (ch_q == '0);

  always_comb begin
    state_d      = state_q;
    start_d      = start_q;
    sel_d        = sel_q;
    mux_d        = mux_q;
    ch_d         = ch_q;
    bit_cnt_d    = bit_cnt_q;
    last_d       = last_q;
    shreg_d      = shreg_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    pend_d       = rd_q;
    rd_d         = 1'b0;
    addr_d       = addr_q;
    ready_d      = ready_q;
    done_d       = 1'b0;
    underrun_d   = underrun_q;

    if (slice_start) begin
      state_d      = IDLE;
      start_d      = 1'b1;
      sel_d        = buffer_select;
      mux_d        = '0;
      ch_d         = CH_W'(NB_CHANNELS - 1);
      bit_cnt_d    = '0;
      last_d       = 1'b0;
      hold_valid_d = 1'b0;
      ready_d      = 1'b0;
      underrun_d   = 1'b0;
    end else begin
      if (shift_en && !ready_q) underrun_d = 1'b1;
      case (state_q)
        IDLE: begin
          if (start_q) begin
            start_d = 1'b0;
            rd_d    = 1'b1;
            addr_d  = {sel_q, mux_q, ch_q};
            state_d = PREFETCH;
          end
        end
        PREFETCH: begin
          if (pend_q) begin
            shreg_d   = ram_dat;
            bit_cnt_d = '0;
            rd_d      = 1'b1;
            ch_d      = next_ch;
            mux_d     = next_mux;
            addr_d    = {sel_q, next_mux, next_ch};
            ready_d   = 1'b1;
            state_d   = STREAM;
          end
        end
        STREAM: begin
          if (pend_q) begin
            hold_d       = ram_dat;
            hold_valid_d = 1'b1;
          end
          if (shift_en) begin
            if (bit_cnt_q == 4'(GS_BITS - 1)) begin
              if (last_q) begin
                ready_d = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
              end else begin
                shreg_d      = hold_valid_q ? hold_q : '0;
                hold_valid_d = 1'b0;
                bit_cnt_d    = '0;
                if (!hold_valid_q) underrun_d = 1'b1;
                if (at_last_addr) begin
                  last_d = 1'b1;
                end else begin
                  rd_d   = 1'b1;
                  ch_d   = next_ch;
                  mux_d  = next_mux;
                  addr_d = {sel_q, next_mux, next_ch};
                end
              end
            end else begin
              shreg_d   = shifted;
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_lse) begin
    if (!nrst) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      sel_q        <= 1'b0;
      mux_q        <= '0;
      ch_q         <= '0;
      bit_cnt_q    <= '0;
      last_q       <= 1'b0;
      shreg_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      pend_q       <= 1'b0;
      rd_q         <= 1'b0;
      addr_q       <= '0;
      ready_q      <= 1'b0;
      done_q       <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      sel_q        <= sel_d;
      mux_q        <= mux_d;
      ch_q         <= ch_d;
      bit_cnt_q    <= bit_cnt_d;
      last_q       <= last_d;
      shreg_q      <= shreg_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      pend_q       <= pend_d;
      rd_q         <= rd_d;
      addr_q       <= addr_d;
      ready_q      <= ready_d;
      done_q       <= done_d;
      underrun_q   <= underrun_d;
    end
  end

  assign ram_rd       = rd_q;
  assign ram_addr     = addr_q;
  assign stream_ready = ready_q;
  assign slice_done   = done_q;
  assign underrun     = underrun_q;

endmodule
